// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports with a
// shared valid strobe. Optional hardwired-zero entry 0 and write-first bypass.
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR1,
    input  logic [ADDR_W-1:0] RADDR2,
    output logic [WIDTH-1:0]  RDATA1,
    output logic [WIDTH-1:0]  RDATA2,
    output logic              RVALID
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            wsel;
    logic [WIDTH-1:0]            rd1, rd2;
    logic [WIDTH-1:0]            rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic                        rvalid_q, rvalid_d;

    // One-hot write select; the zero entry is masked out so it can never load.
    always_comb begin
        wsel = '0;
        if (WE) wsel[WADDR] = 1'b1;
        if (ZERO_REG != 0) wsel[0] = 1'b0;
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wsel[i]) mem_d[i] = WDATA;
        end
    end

    // wsel already folds in WE, the address match and the zero-entry mask,
    // so it doubles as the bypass hit for each read port.
    always_comb begin
        rd1 = mem_q[RADDR1];
        rd2 = mem_q[RADDR2];
        if (BYPASS != 0 && wsel[RADDR1]) rd1 = WDATA;
        if (BYPASS != 0 && wsel[RADDR2]) rd2 = WDATA;
        if (ZERO_REG != 0 && RADDR1 == '0) rd1 = '0;
        if (ZERO_REG != 0 && RADDR2 == '0) rd2 = '0;
    end

    always_comb begin
        rdata1_d = RE ? rd1 : rdata1_q;
        rdata2_d = RE ? rd2 : rdata2_q;
        rvalid_d = RE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign RDATA1 = rdata1_q;
    assign RDATA2 = rdata2_q;
    assign RVALID = rvalid_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Drives three register-file configurations from one stimulus stream and
// compares each against an array-based model of the read/write rules.
module tb_reg_file_param;
    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [7:0]  c_rd1, c_rd2;
    logic        a_vld, b_vld, c_vld;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // A: defaults, B: read-first, C: narrow with no zero register
    reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLK(clk), .RESET(rst), .WE(we), .WADDR(waddr), .WDATA(wdata), .RE(re),
        .RADDR1(raddr1), .RADDR2(raddr2), .RDATA1(a_rd1), .RDATA2(a_rd2), .RVALID(a_vld));
    reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .CLK(clk), .RESET(rst), .WE(we), .WADDR(waddr), .WDATA(wdata), .RE(re),
        .RADDR1(raddr1), .RADDR2(raddr2), .RDATA1(b_rd1), .RDATA2(b_rd2), .RVALID(b_vld));
    reg_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .CLK(clk), .RESET(rst), .WE(we), .WADDR(waddr[2:0]), .WDATA(wdata[7:0]), .RE(re),
        .RADDR1(raddr1[2:0]), .RADDR2(raddr2[2:0]), .RDATA1(c_rd1), .RDATA2(c_rd2), .RVALID(c_vld));

    logic [31:0] wmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    logic [4:0]  amask [3] = '{5'd31, 5'd31, 5'd7};
    bit          zr    [3] = '{1'b1, 1'b1, 1'b0};
    bit          bp    [3] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] mem   [3][32];
    logic [31:0] e_rd1 [3] = '{0, 0, 0};
    logic [31:0] e_rd2 [3] = '{0, 0, 0};
    logic [31:0] e_vld [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [4:0] a,
                                               input logic wr, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (zr[k] && a == 5'd0) return 32'h0;
        if (bp[k] && wr && wa == a) return wd;
        return mem[k][a];
    endfunction

    // Next-cycle expected outputs from the current model contents and inputs.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            logic        wr;
            wa = waddr & amask[k];
            a1 = raddr1 & amask[k];
            a2 = raddr2 & amask[k];
            wd = wdata & wmask[k];
            wr = we && !(zr[k] && wa == 5'd0);
            if (rst) begin
                for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
                e_rd1[k] = 0;
                e_rd2[k] = 0;
                e_vld[k] = 0;
            end else begin
                if (re) begin
                    e_rd1[k] = model_read(k, a1, wr, wa, wd);
                    e_rd2[k] = model_read(k, a2, wr, wa, wd);
                    e_vld[k] = 1;
                end else begin
                    e_vld[k] = 0;
                end
                if (wr) mem[k][wa] = wd;
            end
        end
    endtask

    task automatic check_all();
        chk("A.rdata1", a_rd1, e_rd1[0]);
        chk("A.rdata2", a_rd2, e_rd2[0]);
        chk("A.rvalid", {31'h0, a_vld}, e_vld[0]);
        chk("B.rdata1", b_rd1, e_rd1[1]);
        chk("B.rdata2", b_rd2, e_rd2[1]);
        chk("B.rvalid", {31'h0, b_vld}, e_vld[1]);
        chk("C.rdata1", {24'h0, c_rd1}, e_rd1[2]);
        chk("C.rdata2", {24'h0, c_rd2}, e_rd2[2]);
        chk("C.rvalid", {31'h0, c_vld}, e_vld[2]);
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic rq,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd; re = rq; raddr1 = a1; raddr2 = a2;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // reset, then read of a cleared file
        drive(1, 1, 5'd3, 32'h1234_5678, 1, 5'd3, 5'd3);
        chk("reset.rvalid", {31'h0, a_vld}, 32'h0);
        drive(0, 0, 0, 0, 1, 5'd5, 5'd31);
        chk("p1.rdata2", a_rd2, 32'h0);
        chk("p1.rvalid", {31'h0, a_vld}, 32'h1);

        // fill every entry, then read back in pairs
        drive(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
        for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), 32'hA5A5_0000 + i, 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 1, 5'(i), 5'((32 - i) & 31));
        drive(0, 0, 0, 0, 1, 5'd0, 5'd31);
        chk("p2.zero", a_rd1, 32'h0);
        chk("p2.e31", a_rd2, 32'hA5A5_001F);

        // same-cycle read/write of one address
        drive(0, 1, 5'd7, 32'h1111_1111, 0, 0, 0);
        drive(0, 1, 5'd7, 32'h2222_2222, 1, 5'd7, 5'd7);
        chk("p3.A.bypass1", a_rd1, 32'h2222_2222);
        chk("p3.A.bypass2", a_rd2, 32'h2222_2222);
        chk("p3.B.old1", b_rd1, 32'h1111_1111);
        chk("p3.B.old2", b_rd2, 32'h1111_1111);
        drive(0, 0, 0, 0, 1, 5'd7, 5'd7);
        chk("p3.B.reread", b_rd1, 32'h2222_2222);

        // RE low holds data and drops valid
        drive(0, 1, 5'd3, 32'h3, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 5'd3, 5'd1);
        chk("p4.read", a_rd1, 32'h3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 5'(10 + i), 5'(20 + i));
            chk("p4.hold", a_rd1, 32'h3);
            chk("p4.novalid", {31'h0, a_vld}, 32'h0);
        end

        // reset in the middle of a read stream with a concurrent write
        for (int i = 1; i < 7; i++) drive(0, 1, 5'(i), $urandom, 1, 5'(i - 1), 5'(i));
        drive(1, 1, 5'd4, 32'hDEAD_BEEF, 1, 5'd4, 5'd4);
        chk("p5.rvalid", {31'h0, a_vld}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 1, 5'(i), 5'd4);
            chk("p5.cleared", a_rd1 | a_rd2, 32'h0);
        end

        // narrow config without a zero register
        drive(0, 1, 5'd0, 32'h5A, 0, 0, 0);
        drive(0, 1, 5'd7, 32'hC3, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 5'd0, 5'd7);
        chk("p6.C.e0", {24'h0, c_rd1}, 32'h5A);
        chk("p6.C.e7", {24'h0, c_rd2}, 32'hC3);
        chk("p6.C.rvalid", {31'h0, c_vld}, 32'h1);

        // random traffic, biased toward read/write address collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            drive($urandom_range(0, 63) == 0, 1'($urandom), wa, $urandom,
                  $urandom_range(0, 3) != 0, a1, a2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised multi-entry register file. It generalises the fixed 32-bit REG32 storage into DEPTH entries of WIDTH bits, with one write port and two read ports. Write selection is a one-hot decode of the write address; reads are registered with a valid strobe. It is the datapath register file feeding the ALU operands in the processor.

Parameters:
- WIDTH, 32, data bits per entry.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, if 1 then entry 0 is hardwired to zero and writes to it are discarded.
- BYPASS, 1, if 1 then a same-cycle read of the address being written returns WDATA (write-first); if 0 it returns the old contents (read-first).

Ports:
- CLK, input, 1, rising-edge clock.
- RESET, input, 1, synchronous active-high reset.
- WE, input, 1, write enable.
- WADDR, input, ADDR_W, write address.
- WDATA, input, WIDTH, write data.
- RE, input, 1, read request; both read ports sample on the same cycle.
- RADDR1, input, ADDR_W, read port 1 address.
- RADDR2, input, ADDR_W, read port 2 address.
- RDATA1, output, WIDTH, registered read data, port 1.
- RDATA2, output, WIDTH, registered read data, port 2.
- RVALID, output, 1, high for one cycle when RDATA1/RDATA2 carry the result of a read.

Behaviour:
- Reset: only synchronous reset exists; no asynchronous path. On the rising edge of CLK with RESET=1:
  - all DEPTH entries clear to 0;
  - RDATA1, RDATA2 and RVALID clear to 0;
  - WE and RE in that cycle are ignored.
- Reset asserted mid-operation aborts any pending read: RVALID is 0 on the following cycle.
- Write:
  - On a rising edge with RESET=0 and WE=1, entry[WADDR] <= WDATA.
  - Write latency is 1 cycle.
  - Exactly one entry is enabled, via a one-hot decode of WADDR; all other entries hold.
- ZERO_REG=1:
  - a write to address 0 is discarded;
  - a read of address 0 always returns 0, including under bypass.
- Read:
  - On a rising edge with RESET=0 and RE=1, RDATA1 <= entry[RADDR1] and RDATA2 <= entry[RADDR2].
  - RVALID <= 1 on that edge; latency is 1 cycle from request to data.
- With RE=0: RDATA1/RDATA2 hold their previous values and RVALID <= 0.
- Back-to-back reads (RE held high) produce new data and RVALID=1 every cycle.
- Simultaneous read and write to the same address in one cycle:
  - BYPASS=1: the read port returns WDATA;
  - BYPASS=0: the read port returns the pre-write contents.
  - This applies independently to each read port. Both ports may hit the same address.
- Both read ports may address the same entry; both return identical data.
- Address range: DEPTH is a power of two, so every address is valid; there is no wrap or out-of-range case.
- Storage holds indefinitely while WE=0 and RESET=0.

Test Plan:
1. Reset then read, WIDTH=32, ADDR_W=5: assert RESET for 1 cycle, then RE=1 with RADDR1=5, RADDR2=31 -> next cycle RDATA1=0, RDATA2=0, RVALID=1. During the reset cycle RVALID=0.
2. Write/read-back of all entries:
   - write entry i = 32'hA5A50000+i for i=1..31, then read pairs (i, 32-i);
   - -> each port returns its written value one cycle after RE; entry 0 reads 0 (ZERO_REG=1);
   - a prior write of 32'hFFFFFFFF to address 0 still reads 0.
3. Same-cycle bypass: entry 7 holds 32'h11111111; in one cycle WE=1, WADDR=7, WDATA=32'h22222222, RE=1, RADDR1=RADDR2=7.
   - BYPASS=1 -> RDATA1=RDATA2=32'h22222222;
   - BYPASS=0 -> both 32'h11111111, then a re-read gives 32'h22222222.
4. RE low hold: after a read returning 32'h00000003 on RDATA1, drive RE=0 for 3 cycles with a changing RADDR1 -> RDATA1 stays 32'h00000003 and RVALID=0 for those 3 cycles.
5. Reset mid-stream: entries written and RE=1 streaming; assert RESET for one cycle concurrent with WE=1, WADDR=4, WDATA=32'hDEADBEEF -> all entries read 0 afterward (entry 4=0) and RVALID=0 on the cycle after reset.
6. Alternate parameters WIDTH=8, ADDR_W=3, ZERO_REG=0: write 8'h5A to address 0 and 8'hC3 to address 7, then read (0, 7) -> RDATA1=8'h5A, RDATA2=8'hC3, RVALID=1.
